multicycle_control_unit: RTL

- Moore/Mealy FSM that sequences the shared multicycle RV32I datapath: PC, IR, register file, immediate generator, ALU, ALUOut, MDR, and one unified memory port.
- Decodes the opcode held in IR and drives every write-enable and mux select.
- Handshakes with memory on a req/ready basis.
- Sits beside the datapath top; the datapath holds OldPC (PC latched on IRWrite), ALUOut and MDR registers.

---
 rtl/riscv_ctrl_pkg.sv | 54 +++++
 rtl/multicycle_control_unit_if.sv | 39 +++
 rtl/multicycle_control_unit_branch_resolver.sv | 27 ++
 rtl/multicycle_control_unit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states,
// opcodes and every datapath mux-select code.
package riscv_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH   = 4'd0;
    localparam state_t S_DECODE  = 4'd1;
    localparam state_t S_EXEC_R  = 4'd2;
    localparam state_t S_EXEC_I  = 4'd3;
    localparam state_t S_ADDR    = 4'd4;
    localparam state_t S_MEM_RD  = 4'd5;
    localparam state_t S_MEM_WR  = 4'd6;
    localparam state_t S_WB_ALU  = 4'd7;
    localparam state_t S_WB_MEM  = 4'd8;
    localparam state_t S_BRANCH  = 4'd9;
    localparam state_t S_JAL     = 4'd10;
    localparam state_t S_JALR    = 4'd11;
    localparam state_t S_LUI     = 4'd12;
    localparam state_t S_ILLEGAL = 4'd13;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;
    localparam logic [1:0] WB_IMM    = 2'b11;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control bundle between the multicycle control unit (master) and the
// datapath/memory side (slave).
interface multicycle_control_unit_if;

    logic [31:0] Instruction_i;
    logic        Zero_i;
    logic        Lt_i;
    logic        Ltu_i;
    logic        MemReady_i;

    logic        MemReq_o;
    logic        MemWe_o;
    logic        IorD_o;
    logic        IRWrite_o;
    logic        PCWrite_o;
    logic [1:0]  PCSource_o;
    logic [1:0]  ALUSrcA_o;
    logic [1:0]  ALUSrcB_o;
    logic [1:0]  ALUOp_o;
    logic        RegWrite_o;
    logic [1:0]  MemToReg_o;
    logic        Retire_o;
    logic        Illegal_o;

    modport master (
        input  Instruction_i, Zero_i, Lt_i, Ltu_i, MemReady_i,
        output MemReq_o, MemWe_o, IorD_o, IRWrite_o, PCWrite_o, PCSource_o,
               ALUSrcA_o, ALUSrcB_o, ALUOp_o, RegWrite_o, MemToReg_o,
               Retire_o, Illegal_o
    );

    modport slave (
        output Instruction_i, Zero_i, Lt_i, Ltu_i, MemReady_i,
        input  MemReq_o, MemWe_o, IorD_o, IRWrite_o, PCWrite_o, PCSource_o,
               ALUSrcA_o, ALUSrcB_o, ALUOp_o, RegWrite_o, MemToReg_o,
               Retire_o, Illegal_o
    );

endinterface

// File: rtl/multicycle_control_unit_branch_resolver.sv
// Resolves a conditional branch from funct3 and the ALU comparator flags;
// also flags the two funct3 codes that are not valid branches.
module branch_resolver (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken,
    output logic       invalid
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        taken   = 1'b0;
        invalid = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// FSM sequencing the shared multicycle RV32I datapath: decodes IR, drives all
// enables and mux selects, and handshakes with the unified memory port.
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
(
    input  logic                               Clk_i,
    input  logic                               Reset_i,
    multicycle_control_unit_if.master          bus
);

    state_t     state;
    state_t     state_next;
    state_t     decode_next;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       br_taken;
    logic       br_invalid;

    assign opcode = bus.Instruction_i[6:0];
    assign funct3 = bus.Instruction_i[14:12];

    branch_resolver u_branch_resolver (
        .funct3  (funct3),
        .zero    (bus.Zero_i),
        .lt      (bus.Lt_i),
        .ltu     (bus.Ltu_i),
        .taken   (br_taken),
        .invalid (br_invalid)
    );

    always_ff @(posedge Clk_i) begin
        // NOTE: state registers use non-blocking assignment so all flops update together.
        if (Reset_i) state <= S_FETCH;
        else         state <= state_next;
    end

    always_comb begin
        decode_next = S_ILLEGAL;
        case (opcode)
            OP_OP:             decode_next = S_EXEC_R;
            OP_IMM:            decode_next = S_EXEC_I;
            OP_LOAD, OP_STORE: decode_next = S_ADDR;
            OP_BRANCH:         decode_next = br_invalid ? S_ILLEGAL : S_BRANCH;
            OP_JAL:            decode_next = S_JAL;
            OP_JALR:           decode_next = (funct3 == 3'b000) ? S_JALR : S_ILLEGAL;
            OP_LUI:            decode_next = S_LUI;
            OP_AUIPC:          decode_next = S_WB_ALU;
            default:           decode_next = S_ILLEGAL;
        endcase
    end

    always_comb begin
        state_next     = state;
        bus.MemReq_o   = 1'b0;
        bus.MemWe_o    = 1'b0;
        bus.IorD_o     = 1'b0;
        bus.IRWrite_o  = 1'b0;
        bus.PCWrite_o  = 1'b0;
        bus.PCSource_o = PCSRC_ALU;
        bus.ALUSrcA_o  = SRCA_PC;
        bus.ALUSrcB_o  = SRCB_RS2;
        bus.ALUOp_o    = ALUOP_ADD;
        bus.RegWrite_o = 1'b0;
        bus.MemToReg_o = WB_ALUOUT;
        bus.Retire_o   = 1'b0;
        bus.Illegal_o  = 1'b0;

        // Reset forces every output quiet, abandoning any pending memory request.
        if (!Reset_i) begin
            case (state)
                S_FETCH: begin
                    bus.MemReq_o  = 1'b1;
                    bus.ALUSrcB_o = SRCB_FOUR;
                    if (bus.MemReady_i) begin
                        bus.IRWrite_o = 1'b1;
                        bus.PCWrite_o = 1'b1;
                        state_next    = S_DECODE;
                    end
                end
                S_DECODE: begin
                    bus.ALUSrcA_o = SRCA_OLDPC;
                    bus.ALUSrcB_o = SRCB_IMM;
                    state_next    = decode_next;
                end
                S_EXEC_R: begin
                    bus.ALUSrcA_o = SRCA_RS1;
                    bus.ALUOp_o   = ALUOP_R;
                    state_next    = S_WB_ALU;
                end
                S_EXEC_I: begin
                    bus.ALUSrcA_o = SRCA_RS1;
                    bus.ALUSrcB_o = SRCB_IMM;
                    bus.ALUOp_o   = ALUOP_I;
                    state_next    = S_WB_ALU;
                end
                S_ADDR: begin
                    bus.ALUSrcA_o = SRCA_RS1;
                    bus.ALUSrcB_o = SRCB_IMM;
                    state_next    = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    bus.MemReq_o = 1'b1;
                    bus.IorD_o   = 1'b1;
                    if (bus.MemReady_i) state_next = S_WB_MEM;
                end
                S_MEM_WR: begin
                    bus.MemReq_o = 1'b1;
                    bus.MemWe_o  = 1'b1;
                    bus.IorD_o   = 1'b1;
                    if (bus.MemReady_i) begin
                        bus.Retire_o = 1'b1;
                        state_next   = S_FETCH;
                    end
                end
                S_WB_ALU: begin
                    bus.RegWrite_o = 1'b1;
                    bus.Retire_o   = 1'b1;
                    state_next     = S_FETCH;
                end
                S_WB_MEM: begin
                    bus.RegWrite_o = 1'b1;
                    bus.MemToReg_o = WB_MDR;
                    bus.Retire_o   = 1'b1;
                    state_next     = S_FETCH;
                end
                S_BRANCH: begin
                    bus.ALUSrcA_o  = SRCA_RS1;
                    bus.ALUOp_o    = ALUOP_SUB;
                    bus.PCSource_o = PCSRC_ALUOUT;
                    bus.PCWrite_o  = br_taken;
                    bus.Retire_o   = 1'b1;
                    state_next     = S_FETCH;
                end
                S_JAL: begin
                    bus.RegWrite_o = 1'b1;
                    bus.MemToReg_o = WB_PC;
                    bus.PCWrite_o  = 1'b1;
                    bus.PCSource_o = PCSRC_ALUOUT;
                    bus.Retire_o   = 1'b1;
                    state_next     = S_FETCH;
                end
                S_JALR: begin
                    bus.ALUSrcA_o  = SRCA_RS1;
                    bus.ALUSrcB_o  = SRCB_IMM;
                    bus.RegWrite_o = 1'b1;
                    bus.MemToReg_o = WB_PC;
                    bus.PCWrite_o  = 1'b1;
                    bus.PCSource_o = PCSRC_JALR;
                    bus.Retire_o   = 1'b1;
                    state_next     = S_FETCH;
                end
                S_LUI: begin
                    bus.RegWrite_o = 1'b1;
                    bus.MemToReg_o = WB_IMM;
                    bus.Retire_o   = 1'b1;
                    state_next     = S_FETCH;
                end
                S_ILLEGAL: begin
                    bus.Illegal_o = 1'b1;
                end
                default: begin
                    state_next = S_ILLEGAL;
                end
            endcase
        end
    end

endmodule
